rc_seq_addsub: RTL
==================

Name: rc_seq_addsub

Overview:
- Parametrised, digit-serial successor to the 16-bit ripple-carry adder.
- Computes a+b+cin or a-b-cin over WIDTH/DIGIT clock cycles, DIGIT bits per cycle, through a DIGIT-bit ripple slice and a registered carry.
- Trades latency for area and uses a start/busy/done handshake.
- Used wherever wide operands must be added without a full-width combinational carry chain.

Parameters:
- WIDTH, 16, operand and result width in bits. Must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle, 1..WIDTH. DIGIT=WIDTH gives a 1-cycle adder.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when busy=0.
- sub  input  1  0: a+b+cin; 1: a-b-cin. Latched on start.
- a  input  WIDTH  operand A. Latched on start.
- b  input  WIDTH  operand B. Latched on start.
- cin  input  1  carry-in (add) or borrow-in (sub). Latched on start.
- busy  output  1  high while the operation is in progress.
- done  output  1  one-cycle pulse when the result is valid.
- s  output  WIDTH  result; held until the next accepted start.
- cout  output  1  carry out of bit WIDTH-1. For sub, 1 means no borrow.
- ovf  output  1  signed two's-complement overflow.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, busy=0, done=0, s=0, cout=0, ovf=0, digit counter=0, internal operand and carry registers=0. Reset mid-operation aborts it; no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE, start=1: latch a, b_eff = sub ? ~b : b, carry = sub ? ~cin : cin; counter=0; go to RUN; busy=1 from the next cycle.
- RUN, each cycle:
  - Add digit k: A[k*DIGIT +: DIGIT] + B_eff[...] + carry, using a DIGIT-bit ripple slice.
  - Write the sum digit into the s shift/position register; register carry-out as carry.
  - Increment k.
- RUN, last digit (k = WIDTH/DIGIT-1): capture cout = final carry and ovf = (A[MSB]==B_eff[MSB]) && (sum[MSB]!=A[MSB]); go to DONE.
- DONE: done=1, busy=0 for exactly one cycle.
  - start=1 here is accepted exactly as in IDLE (back-to-back operations); otherwise go to IDLE.
- Latency: accepted start at edge N gives done=1 in the cycle after edge N+WIDTH/DIGIT. For WIDTH=16, DIGIT=4, done is high 4 cycles after the start edge.
- start while busy=1 is ignored. Input changes while busy do not affect the result.
- s may show partial digits while busy. s, cout and ovf are valid only from done onward and hold until the next accepted start.
- All arithmetic is modulo 2^WIDTH.
- sub=1 results equal a - b - cin modulo 2^WIDTH.

Optional Feature:
- Macro RC_SAT_EN.
- Defined: when ovf would be 1, s is clamped at the DONE transition.
  - Positive overflow (A[MSB]=0) gives s = {0, all 1s}, e.g. 0x7FFF.
  - Negative overflow gives s = {1, all 0s}, e.g. 0x8000.
  - ovf is still reported as 1; cout is unchanged (raw carry).
  - Costs one extra mux on s and no extra cycles.
- Not defined: s wraps modulo 2^WIDTH; no clamp logic is generated.

Test Plan (WIDTH=16, DIGIT=4 unless stated):
- a=0x001F, b=0x000C, cin=0, sub=0, one start pulse -> busy high 4 cycles, then done pulse, s=0x002B, cout=0, ovf=0.
- a=0xFFFF, b=0x0000, cin=1 -> s=0x0000, cout=1, ovf=0.
- a=0x7FFF, b=0x0001, cin=0 -> ovf=1. s=0x8000 without RC_SAT_EN; s=0x7FFF with RC_SAT_EN.
- a=0x0005, b=0x0007, sub=1, cin=0 -> s=0xFFFE, cout=0, ovf=0.
  - Follow-up: start held high through the done cycle with a=0xC61F, b=0x018C, sub=0 -> second done exactly 5 cycles after the first, s=0xC7AB.
- Start accepted, then start re-pulsed and a/b changed in cycle 2 -> request ignored, original result returned. Then rst_n=0 in cycle 2 of a new operation -> busy=0, s=0, no done pulse.
- Repeat the first two scenarios with DIGIT=1 (16-cycle latency) and DIGIT=16 (1-cycle latency) -> identical s and cout.

Source files
------------

// File: rtl/rc_seq_addsub.sv
// rc_seq_addsub: digit-serial adder/subtractor.
// Processes DIGIT bits per cycle through a DIGIT-bit ripple slice with a registered carry,
// so a WIDTH-bit operation takes WIDTH/DIGIT cycles after an accepted start.
// Optional build macro RC_SAT_EN: clamp s to the signed extreme when the result overflows.
module rc_seq_addsub #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned CNTW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNTW-1:0] LAST = CNTW'(NDIG - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]       state_q, state_d;
    // Operands shift right one digit per cycle; the active digit is always the low DIGIT bits.
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [DIGIT-1:0] a_dig, b_dig, sum_dig;
    logic             dig_cout;
    logic             dig_ovf;
    logic [WIDTH-1:0] s_shift;
    logic [WIDTH-1:0] s_final;

    assign a_dig = a_q[DIGIT-1:0];
    assign b_dig = b_q[DIGIT-1:0];

    // DIGIT-bit ripple slice fed by the registered carry.
    always_comb begin : ripple
        logic c;
        c       = carry_q;
        sum_dig = '0;
        for (int i = 0; i < int'(DIGIT); i++) begin
            sum_dig[i] = a_dig[i] ^ b_dig[i] ^ c;
            c          = (a_dig[i] & b_dig[i]) | (c & (a_dig[i] ^ b_dig[i]));
        end
        dig_cout = c;
    end

    // Overflow is only meaningful on the last digit, where bit DIGIT-1 is the operand MSB.
    assign dig_ovf = (a_dig[DIGIT-1] == b_dig[DIGIT-1]) && (sum_dig[DIGIT-1] != a_dig[DIGIT-1]);

    // Result register fills from the top: after NDIG shifts digit 0 sits at the bottom.
    always_comb begin
        s_shift                     = s_q >> DIGIT;
        s_shift[WIDTH-1 -: DIGIT]   = sum_dig;
        s_final                     = s_shift;
`ifdef RC_SAT_EN
        if (dig_ovf) begin
            s_final = a_dig[DIGIT-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    // Next-state: accept in IDLE or DONE, one digit per cycle in RUN.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? ~cin : cin;
                    cnt_d   = '0;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = dig_cout;
                s_d     = s_shift;
                cnt_d   = cnt_q + CNTW'(1);
                if (cnt_q == LAST) begin
                    s_d     = s_final;
                    cout_d  = dig_cout;
                    ovf_d   = dig_ovf;
                    cnt_d   = '0;
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);
    assign s    = s_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
